// File: rtl/vga_stream_gen_pkg.sv
// Shared types and helpers for the VGA stream generator.
//   pixel_t     : 30-bit {r,g,b} pixel, 10 bits per channel
//   state_e     : frame-level state (IDLE, RUN)
//   pack_rgb    : left-justifies a 3*cb-bit {R,G,B} word into pixel_t
package vga_pkg;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } pixel_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [29:0] COLOR_WHITE = 30'h3FFFFFFF;
    localparam logic [29:0] COLOR_BLACK = 30'h0;

    // rgb holds {R,G,B} of cb bits each in its low 3*cb bits; cb <= 10.
    function automatic pixel_t pack_rgb(input logic [29:0] rgb, input int unsigned cb);
        pixel_t      p;
        logic [29:0] m;
        m   = (30'd1 << cb) - 30'd1;
        p.b = 10'(( rgb             & m) << (10 - cb));
        p.g = 10'(((rgb >> cb)      & m) << (10 - cb));
        p.r = 10'(((rgb >> (2 * cb)) & m) << (10 - cb));
        return p;
    endfunction

endpackage

// File: rtl/vga_stream_gen_if.sv
// Avalon-ST video source bundle (readyLatency 0).
//   master : drives data/valid/startofpacket/endofpacket, samples ready
//   slave  : the sink side
interface vga_stream_gen_if;
    logic [29:0] avalon_streaming_source_data;
    logic        avalon_streaming_source_valid;
    logic        avalon_streaming_source_ready;
    logic        avalon_streaming_source_startofpacket;
    logic        avalon_streaming_source_endofpacket;

    modport master (
        output avalon_streaming_source_data,
        output avalon_streaming_source_valid,
        output avalon_streaming_source_startofpacket,
        output avalon_streaming_source_endofpacket,
        input  avalon_streaming_source_ready
    );

    modport slave (
        input  avalon_streaming_source_data,
        input  avalon_streaming_source_valid,
        input  avalon_streaming_source_startofpacket,
        input  avalon_streaming_source_endofpacket,
        output avalon_streaming_source_ready
    );
endinterface

// File: rtl/vga_stream_gen_pos_counter.sv
// Raster position counter: (x,y) of the next pixel to be loaded.
//   clk, rst_n : clock, async active-low reset
//   adv_i      : advance one pixel (a load happens this cycle)
//   x_o        : column of the pending pixel
//   x_nxt_o    : column that will be pending after this cycle
//   sop_o/eop_o       : pending pixel is first/last of the frame
//   row_hit_o/scr_hit_o : pending pixel is the next_row/next_screen trigger
module vga_pos_counter #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int ROW_LEAD    = 80,
    parameter int SCREEN_LEAD = 1040,
    parameter int XW          = $clog2(H_ACTIVE),
    parameter int YW          = $clog2(V_ACTIVE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv_i,
    output logic [XW-1:0] x_o,
    output logic [XW-1:0] x_nxt_o,
    output logic          sop_o,
    output logic          eop_o,
    output logic          row_hit_o,
    output logic          scr_hit_o
);
    localparam int SCR_IDX = H_ACTIVE * V_ACTIVE - SCREEN_LEAD;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [XW-1:0] ROW_X  = XW'(H_ACTIVE - ROW_LEAD);
    localparam logic [XW-1:0] SCR_X  = XW'(SCR_IDX % H_ACTIVE);
    localparam logic [YW-1:0] SCR_Y  = YW'(SCR_IDX / H_ACTIVE);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (adv_i) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o       = x_q;
    assign x_nxt_o   = x_d;
    assign sop_o     = (x_q == '0) && (y_q == '0);
    assign eop_o     = (x_q == X_LAST) && (y_q == Y_LAST);
    assign row_hit_o = (x_q == ROW_X);
    assign scr_hit_o = (x_q == SCR_X) && (y_q == SCR_Y);
endmodule

// File: rtl/vga_stream_gen.sv
// Parametrised Avalon-ST video source.
//   clock_vga, reset_n : pixel clock, async active-low reset
//   enable             : frame enable, only looked at between frames
//   src                : Avalon-ST source (data/valid/ready/SOP/EOP)
//   data, address      : synchronous-read row buffer (1-cycle latency)
//   next_row           : one-cycle row-buffer refill request
//   next_screen        : one-cycle start-of-next-frame request
module vga_stream_gen
    import vga_pkg::*;
#(
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          X_START      = 80,
    parameter int          X_END        = 560,
    parameter bit          BORDER_EN    = 1'b1,
    parameter int          COLOR_BITS   = 8,
    parameter logic [29:0] BORDER_COLOR = COLOR_WHITE,
    parameter logic [29:0] BG_COLOR     = COLOR_BLACK,
    parameter int          ROW_LEAD     = 80,
    parameter int          SCREEN_LEAD  = 1040,
    parameter int          ADDR_W       = 9
) (
    input  logic                    clock_vga,
    input  logic                    reset_n,
    input  logic                    enable,
    vga_stream_gen_if.master        src,
    input  logic [3*COLOR_BITS-1:0] data,
    output logic [ADDR_W-1:0]       address,
    output logic                    next_row,
    output logic                    next_screen
);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam logic [XW-1:0] XS   = XW'(X_START);
    localparam logic [XW-1:0] XE   = XW'(X_END);
    localparam logic [XW-1:0] XB_L = XW'(X_START - 1);
    localparam logic [XW-1:0] XB_R = XW'(X_END + 1);

    state_e        state_q;
    pixel_t        data_q, pix;
    logic          valid_q, sop_q, eop_q, next_row_q, next_screen_q;
    logic [XW-1:0] x, x_nxt;
    logic          sop_hit, eop_hit, row_hit, scr_hit;
    logic          ready, frame_end, load;

    assign ready = src.avalon_streaming_source_ready;

    // The EOP beat leaving with enable low must not also load the next
    // frame's first pixel, so that case takes priority over a load.
    assign frame_end = (state_q == RUN) && valid_q && ready && eop_q && !enable;
    assign load      = (state_q == RUN) && (!valid_q || ready) && !frame_end;

    vga_pos_counter #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .ROW_LEAD   (ROW_LEAD),
        .SCREEN_LEAD(SCREEN_LEAD),
        .XW         (XW),
        .YW         (YW)
    ) u_pos (
        .clk      (clock_vga),
        .rst_n    (reset_n),
        .adv_i    (load),
        .x_o      (x),
        .x_nxt_o  (x_nxt),
        .sop_o    (sop_hit),
        .eop_o    (eop_hit),
        .row_hit_o(row_hit),
        .scr_hit_o(scr_hit)
    );

    // Address is taken from the column that will be pending after this
    // edge, so the buffer has already produced its word when that pixel
    // is loaded, and stays put while the sink stalls.
    always_comb begin
        address = '0;
        if (x_nxt >= XS && x_nxt <= XE) address = ADDR_W'(x_nxt - XS);
    end

    always_comb begin
        pix = BG_COLOR;
        if (x >= XS && x <= XE) begin
            pix = pack_rgb(30'(data), COLOR_BITS);
        end else if (BORDER_EN && (x == XB_L || x == XB_R)) begin
            pix = BORDER_COLOR;
        end
    end

    always_ff @(posedge clock_vga or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            data_q        <= '0;
            valid_q       <= 1'b0;
            sop_q         <= 1'b0;
            eop_q         <= 1'b0;
            next_row_q    <= 1'b0;
            next_screen_q <= 1'b0;
        end else begin
            next_row_q    <= 1'b0;
            next_screen_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_q && ready) valid_q <= 1'b0;
                    // First load comes a cycle later, after address 0 setup.
                    if (enable) state_q <= RUN;
                end
                RUN: begin
                    if (frame_end) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end else if (load) begin
                        data_q        <= pix;
                        valid_q       <= 1'b1;
                        sop_q         <= sop_hit;
                        eop_q         <= eop_hit;
                        next_row_q    <= row_hit;
                        next_screen_q <= scr_hit;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign src.avalon_streaming_source_data          = data_q;
    assign src.avalon_streaming_source_valid         = valid_q;
    assign src.avalon_streaming_source_startofpacket = sop_q;
    assign src.avalon_streaming_source_endofpacket   = eop_q;
    assign next_row    = next_row_q;
    assign next_screen = next_screen_q;
endmodule

// File: doc/vga_stream_gen.md
Name: vga_stream_gen

Overview:
- Parametrised Avalon-ST video source feeding the VGA output pipeline. Generalises the fixed 640x480 streamer: frame size, drawing window, border, colours and lead times are all parameters.
- Adds a correct ready/valid hold, a frame-granular enable, and single-cycle row/screen request pulses for the upstream row-buffer filler.
- Reads pixels from a synchronous-read row buffer (1-cycle read latency).

Parameters:
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- X_START, 80, first drawn column, inclusive; must be >= 1
- X_END, 560, last drawn column, inclusive; must be < H_ACTIVE-1
- BORDER_EN, 1, 1 = emit BORDER_COLOR at columns X_START-1 and X_END+1
- COLOR_BITS, 8, bits per input channel; output channel is 10 bits
- BORDER_COLOR, 30'h3FFFFFFF, border pixel value
- BG_COLOR, 30'h0, pixel value outside the drawing window
- ROW_LEAD, 80, next_row fires when column H_ACTIVE-ROW_LEAD is accepted
- SCREEN_LEAD, 1040, next_screen fires when linear index H_ACTIVE*V_ACTIVE-SCREEN_LEAD is accepted
- ADDR_W, 9, row-buffer address width; must satisfy 2^ADDR_W >= X_END-X_START+1

Ports:
- clock_vga  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  stream enable, sampled only at frame boundaries
- avalon_streaming_source_data  out  30  {R,G,B} at 10 bits each
- avalon_streaming_source_valid  out  1  data valid
- avalon_streaming_source_ready  in  1  sink ready (readyLatency 0)
- avalon_streaming_source_startofpacket  out  1  pixel (0,0)
- avalon_streaming_source_endofpacket  out  1  pixel (H_ACTIVE-1, V_ACTIVE-1)
- data  in  3*COLOR_BITS  row-buffer read data, {R,G,B}
- address  out  ADDR_W  row-buffer read address
- next_row  out  1  one-cycle request to refill the row buffer
- next_screen  out  1  one-cycle start-of-next-frame request

Behaviour:

Reset values:
- valid=0, data=0, SOP=0, EOP=0, next_row=0, next_screen=0, address=0.
- Column counter x=0, row counter y=0, state=IDLE.
- Reset mid-frame aborts the frame immediately; no EOP is emitted.

State machine:
- IDLE: if enable=1, go to RUN. Otherwise stay, with valid=0.
- RUN: generate pixels. After EOP is accepted, go to RUN if enable=1, else IDLE.
- enable is ignored inside a frame.

Load rule:
- load = RUN && (!valid || ready).
- On load: output register takes the pixel for (x,y), valid=1, and x/y advance.
- When not loading: data, valid, SOP and EOP hold unchanged while ready=0.
- In IDLE, the accepted beat clears valid.

Pixel value for column x:
- X_START <= x <= X_END: each channel is {channel, 2'b0} (left-justified to 10 bits, for COLOR_BITS=8). Address increments on this load.
- x == X_START-1 or x == X_END+1, with BORDER_EN: BORDER_COLOR.
- Otherwise: BG_COLOR.

Addressing:
- address always indexes the pixel about to be loaded, so data is stable while stalled.
- address stays 0 outside the window.
- address is forced to 0 when x wraps at H_ACTIVE-1.

Counters:
- x wraps at H_ACTIVE-1, then y increments.
- y wraps at V_ACTIVE-1, then the frame ends.

Flags:
- SOP=1 on the beat for (0,0); EOP=1 on the beat for the last pixel.

Pulses:
- next_row and next_screen are registered, high exactly one cycle, on the load of the trigger pixel.
- Stalls never repeat a pulse.

First beat:
- Leaving IDLE for RUN: first load occurs one cycle later, giving the row buffer 1 cycle of address setup at address 0.

Decomposition:
- Package vga_pkg holds:
  - pixel_t (30-bit {r,g,b} struct)
  - COLOR_WHITE and COLOR_BLACK constants
  - the state enum {IDLE, RUN}
  - a function packing 3*COLOR_BITS into pixel_t
- One sub-module is natural: vga_pos_counter (x/y counters, wrap, SOP/EOP, trigger compares). The top level holds the FSM, output register and address logic.

Test Plan:
- Defaults, ready=1, enable=1, data = address replicated -> 307200 beats between SOP and EOP. Per line: columns 0–78 = 0, 79 = 3FFFFFFF, 80–560 = buffer words 0–480, 561 = 3FFFFFFF, rest = 0. address returns to 0 at each line start.
- Stall: ready=0 for 5 cycles at column 300 -> data, valid and address unchanged. No extra next_row when column 560 is later accepted; exactly 480 next_row pulses per frame.
- Drop enable mid-frame -> frame completes through EOP, then valid=0. Re-assert -> next beat has SOP=1 at (0,0).
- Assert reset_n=0 asynchronously at pixel 1000 -> all outputs go to reset values without waiting for a clock edge. After release with enable=1, the first accepted beat has SOP=1.
- Params H_ACTIVE=16, V_ACTIVE=4, X_START=4, X_END=11, BORDER_EN=0, SCREEN_LEAD=20 -> 64 beats per frame. Columns 3 and 12 = BG_COLOR. next_screen fires on the acceptance of index 44.
- Random ready (50%) over 3 frames -> reference-model comparison passes, with exactly one SOP and one EOP per frame.
